// File: rtl/execute_stage.sv
// EX stage: operand forwarding (optional, FORWARDING_EN), 16-bit ALU, {C,N,Z} condition codes,
// and the EX/MEM pipeline register consumed by memory_stage.
module execute_stage #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned RADDR = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] read_data1,
  input  logic [WIDTH-1:0] read_data2,
  input  logic [WIDTH-1:0] sign_extend_from_id,
  input  logic             use_imm,
  input  logic [RADDR-1:0] rs_addr,
  input  logic [RADDR-1:0] rt_addr,
  input  logic [RADDR-1:0] reg_write_address_from_id,
  input  logic             RegWrite,
  input  logic             memory_read,
  input  logic             memory_write,
  input  logic             memory_push,
  input  logic             memory_pop,
  input  logic             write_back_select,
  input  logic             wb_RegWrite,
  input  logic [RADDR-1:0] wb_reg_write_address,
  input  logic [WIDTH-1:0] wb_data,
  output logic [WIDTH-1:0] alu_result_r,
  output logic [WIDTH-1:0] address_r,
  output logic [WIDTH-1:0] write_data_r,
  output logic [WIDTH-1:0] sign_extend_r,
  output logic [RADDR-1:0] reg_write_address_r,
  output logic             RegWrite_r,
  output logic             memory_read_r,
  output logic             memory_write_r,
  output logic             memory_push_r,
  output logic             memory_pop_r,
  output logic             write_back_select_r,
  output logic [2:0]       ccr_r
);

  typedef enum logic [3:0] {
    OpNop  = 4'h0,
    OpNot  = 4'h1,
    OpInc  = 4'h2,
    OpDec  = 4'h3,
    OpAdd  = 4'h4,
    OpSub  = 4'h5,
    OpAnd  = 4'h6,
    OpOr   = 4'h7,
    OpShl  = 4'h8,
    OpShr  = 4'h9,
    OpMov  = 4'hA,
    OpSetc = 4'hB,
    OpClrc = 4'hC
  } alu_op_e;

  logic [WIDTH-1:0] fwd_a, fwd_b, op_b;
  logic [WIDTH-1:0] alu_d;
  logic [WIDTH:0]   t;
  logic [3:0]       sh;
  logic             c_d, zn_upd;
  logic [2:0]       ccr_d;

`ifdef FORWARDING_EN
  // Loads are excluded: their alu_result_r is an address, not the loaded value.
  always_comb begin
    fwd_a = read_data1;
    if (RegWrite_r && !memory_read_r && (reg_write_address_r == rs_addr)) begin
      fwd_a = alu_result_r;
    end else if (wb_RegWrite && (wb_reg_write_address == rs_addr)) begin
      fwd_a = wb_data;
    end
    fwd_b = read_data2;
    if (RegWrite_r && !memory_read_r && (reg_write_address_r == rt_addr)) begin
      fwd_b = alu_result_r;
    end else if (wb_RegWrite && (wb_reg_write_address == rt_addr)) begin
      fwd_b = wb_data;
    end
  end
`else
  assign fwd_a = read_data1;
  assign fwd_b = read_data2;
  logic unused_fwd;
  assign unused_fwd = ^{wb_RegWrite, wb_reg_write_address, wb_data, rs_addr, rt_addr};
`endif

  assign op_b = use_imm ? sign_extend_from_id : fwd_b;
  assign sh   = op_b[3:0];

  always_comb begin
    alu_d  = fwd_a;
    t      = '0;
    c_d    = ccr_r[2];
    zn_upd = 1'b0;
    case (alu_op)
      OpNot: begin
        alu_d  = ~fwd_a;
        zn_upd = 1'b1;
      end
      OpInc, OpDec, OpAdd, OpSub: begin
        case (alu_op)
          OpInc:   t = {1'b0, fwd_a} + (WIDTH+1)'(1);
          OpDec:   t = {1'b0, fwd_a} - (WIDTH+1)'(1);
          OpAdd:   t = {1'b0, fwd_a} + {1'b0, op_b};
          default: t = {1'b0, fwd_a} - {1'b0, op_b};
        endcase
        // Bit WIDTH is carry for add and borrow for subtract.
        alu_d  = t[WIDTH-1:0];
        c_d    = t[WIDTH];
        zn_upd = 1'b1;
      end
      OpAnd: begin
        alu_d  = fwd_a & op_b;
        zn_upd = 1'b1;
      end
      OpOr: begin
        alu_d  = fwd_a | op_b;
        zn_upd = 1'b1;
      end
      OpShl: begin
        t      = {1'b0, fwd_a} << sh;
        alu_d  = t[WIDTH-1:0];
        c_d    = (sh != 4'd0) ? t[WIDTH] : ccr_r[2];
        zn_upd = 1'b1;
      end
      OpShr: begin
        t      = {fwd_a, 1'b0} >> sh;
        alu_d  = t[WIDTH:1];
        c_d    = (sh != 4'd0) ? t[0] : ccr_r[2];
        zn_upd = 1'b1;
      end
      OpMov:   alu_d = op_b;
      OpSetc:  c_d = 1'b1;
      OpClrc:  c_d = 1'b0;
      default: alu_d = fwd_a;
    endcase
    ccr_d = {c_d,
             zn_upd ? alu_d[WIDTH-1] : ccr_r[1],
             zn_upd ? (alu_d == '0) : ccr_r[0]};
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      alu_result_r        <= '0;
      write_data_r        <= '0;
      sign_extend_r       <= '0;
      reg_write_address_r <= '0;
      RegWrite_r          <= 1'b0;
      memory_read_r       <= 1'b0;
      memory_write_r      <= 1'b0;
      memory_push_r       <= 1'b0;
      memory_pop_r        <= 1'b0;
      write_back_select_r <= 1'b0;
      if (reset) begin
        ccr_r <= 3'b000;
      end
    end else if (!stall) begin
      alu_result_r        <= alu_d;
      write_data_r        <= fwd_b;
      sign_extend_r       <= sign_extend_from_id;
      reg_write_address_r <= reg_write_address_from_id;
      RegWrite_r          <= RegWrite;
      memory_read_r       <= memory_read;
      memory_write_r      <= memory_write;
      memory_push_r       <= memory_push;
      memory_pop_r        <= memory_pop;
      write_back_select_r <= write_back_select;
      ccr_r               <= ccr_d;
    end
  end

  assign address_r = alu_result_r;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: each driven slot pushes its expected EX/MEM contents,
// which are popped and compared one cycle later.
module tb_execute_stage;

  logic        clk;
  logic        reset, stall, flush;
  logic [3:0]  alu_op;
  logic [15:0] read_data1, read_data2, sign_extend_from_id;
  logic        use_imm;
  logic [2:0]  rs_addr, rt_addr, reg_write_address_from_id;
  logic        RegWrite, memory_read, memory_write, memory_push, memory_pop, write_back_select;
  logic        wb_RegWrite;
  logic [2:0]  wb_reg_write_address;
  logic [15:0] wb_data;
  logic [15:0] alu_result_r, address_r, write_data_r, sign_extend_r;
  logic [2:0]  reg_write_address_r;
  logic        RegWrite_r, memory_read_r, memory_write_r, memory_push_r, memory_pop_r;
  logic        write_back_select_r;
  logic [2:0]  ccr_r;

  execute_stage dut (
    .clk                       (clk),
    .reset                     (reset),
    .stall                     (stall),
    .flush                     (flush),
    .alu_op                    (alu_op),
    .read_data1                (read_data1),
    .read_data2                (read_data2),
    .sign_extend_from_id       (sign_extend_from_id),
    .use_imm                   (use_imm),
    .rs_addr                   (rs_addr),
    .rt_addr                   (rt_addr),
    .reg_write_address_from_id (reg_write_address_from_id),
    .RegWrite                  (RegWrite),
    .memory_read               (memory_read),
    .memory_write              (memory_write),
    .memory_push               (memory_push),
    .memory_pop                (memory_pop),
    .write_back_select         (write_back_select),
    .wb_RegWrite               (wb_RegWrite),
    .wb_reg_write_address      (wb_reg_write_address),
    .wb_data                   (wb_data),
    .alu_result_r              (alu_result_r),
    .address_r                 (address_r),
    .write_data_r              (write_data_r),
    .sign_extend_r             (sign_extend_r),
    .reg_write_address_r       (reg_write_address_r),
    .RegWrite_r                (RegWrite_r),
    .memory_read_r             (memory_read_r),
    .memory_write_r            (memory_write_r),
    .memory_push_r             (memory_push_r),
    .memory_pop_r              (memory_pop_r),
    .write_back_select_r       (write_back_select_r),
    .ccr_r                     (ccr_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] CRW = 6'b100000;
  localparam logic [5:0] CLD = 6'b110000;
  localparam logic [5:0] CST = 6'b001000;
  localparam logic [5:0] CPU = 6'b000100;

  typedef struct {
    logic        rst, stall, flush;
    logic [3:0]  op;
    logic [15:0] a, b, se;
    logic        imm;
    logic [2:0]  rs, rt, rd;
    logic [5:0]  ctl;
    logic        wbwe;
    logic [2:0]  wba;
    logic [15:0] wbd;
    logic [75:0] ev, em;
  } stim_t;

  stim_t sb[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [75:0] pk(input logic [15:0] alu, input logic [15:0] wd,
                                     input logic [15:0] se, input logic [2:0] rd,
                                     input logic [5:0] ctl, input logic [2:0] ccr);
    return {alu, alu, wd, se, rd, ctl, ccr};
  endfunction

  function automatic logic [75:0] obs();
    return {alu_result_r, address_r, write_data_r, sign_extend_r, reg_write_address_r,
            RegWrite_r, memory_read_r, memory_write_r, memory_push_r, memory_pop_r,
            write_back_select_r, ccr_r};
  endfunction

  // Default slot: no reset/stall/flush, unmatched source regs, write data = read_data2.
  function automatic stim_t st(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] se, input logic imm, input logic [2:0] rd,
                               input logic [5:0] ctl, input logic [15:0] alu_e,
                               input logic [2:0] ccr_e);
    stim_t t;
    t.rst = 1'b0; t.stall = 1'b0; t.flush = 1'b0;
    t.op = op; t.a = a; t.b = b; t.se = se; t.imm = imm;
    t.rs = 3'd6; t.rt = 3'd7; t.rd = rd; t.ctl = ctl;
    t.wbwe = 1'b0; t.wba = 3'd0; t.wbd = 16'h0;
    t.ev = pk(alu_e, b, se, rd, ctl, ccr_e);
    t.em = '1;
    return t;
  endfunction

  task automatic apply(input stim_t s);
    reset = s.rst; stall = s.stall; flush = s.flush;
    alu_op = s.op; read_data1 = s.a; read_data2 = s.b; sign_extend_from_id = s.se;
    use_imm = s.imm; rs_addr = s.rs; rt_addr = s.rt; reg_write_address_from_id = s.rd;
    {RegWrite, memory_read, memory_write, memory_push, memory_pop, write_back_select} = s.ctl;
    wb_RegWrite = s.wbwe; wb_reg_write_address = s.wba; wb_data = s.wbd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t s[$];
    stim_t t, e;
    t = st(4'h4, 16'hFFFF, 16'h0001, 16'h1111, 1'b0, 3'd7, 6'h3F, 16'h0, 3'b0);
    t.rst = 1'b1;
    t.ev = '0;
    s.push_back(t);
    s.push_back(t);
    s.push_back(st(4'h0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd1, CRW, 16'h0000, 3'b000));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(s[i]); tick();
      e = sb.pop_front(); total++;
      if (((obs() ^ e.ev) & e.em) !== '0) begin
        bad++;
        $display("FAIL reset[%0d] got=%h want=%h", i, obs(), e.ev);
      end
    end
  endtask

  task automatic test_arith();
    stim_t s[$];
    stim_t e;
    s.push_back(st(4'h4, 16'hFFFF, 16'h0001, 16'h0, 1'b0, 3'd2, CRW, 16'h0000, 3'b101));
    s.push_back(st(4'h5, 16'h0003, 16'h1234, 16'h0005, 1'b1, 3'd2, CRW, 16'hFFFE, 3'b110));
    s.push_back(st(4'h3, 16'h0001, 16'h0, 16'h0, 1'b0, 3'd2, CRW, 16'h0000, 3'b001));
    s.push_back(st(4'h3, 16'h0000, 16'h0, 16'h0, 1'b0, 3'd2, CRW, 16'hFFFF, 3'b110));
    s.push_back(st(4'h2, 16'hFFFF, 16'h0, 16'h0, 1'b0, 3'd2, CRW, 16'h0000, 3'b101));
    s.push_back(st(4'h1, 16'h00FF, 16'h0, 16'h0, 1'b0, 3'd2, CRW, 16'hFF00, 3'b110));
    s.push_back(st(4'h6, 16'hF0F0, 16'h0FF0, 16'h0, 1'b0, 3'd2, CRW, 16'h00F0, 3'b100));
    s.push_back(st(4'h7, 16'h0000, 16'h0000, 16'h0, 1'b0, 3'd2, CRW, 16'h0000, 3'b101));
    s.push_back(st(4'h5, 16'h0005, 16'h0003, 16'h0, 1'b0, 3'd2, CRW, 16'h0002, 3'b000));
    s.push_back(st(4'h4, 16'h7FFF, 16'h0001, 16'h0, 1'b0, 3'd2, CRW, 16'h8000, 3'b010));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(s[i]); tick();
      e = sb.pop_front(); total++;
      if (((obs() ^ e.ev) & e.em) !== '0) begin
        bad++;
        $display("FAIL arith[%0d] got=%h want=%h", i, obs(), e.ev);
      end
    end
  endtask

  task automatic test_shift_flags();
    stim_t s[$];
    stim_t t, e;
    s.push_back(st(4'h8, 16'h8001, 16'h0001, 16'h0, 1'b0, 3'd3, CRW, 16'h0002, 3'b100));
    s.push_back(st(4'h8, 16'h8001, 16'h0000, 16'h0, 1'b0, 3'd3, CRW, 16'h8001, 3'b110));
    t = st(4'hC, 16'h1234, 16'h0, 16'h0, 1'b0, 3'd3, CRW, 16'h0, 3'b010);
    t.em = {32'h0, {44{1'b1}}};
    s.push_back(t);
    t = st(4'hB, 16'h1234, 16'h0, 16'h0, 1'b0, 3'd3, CRW, 16'h0, 3'b110);
    t.em = {32'h0, {44{1'b1}}};
    s.push_back(t);
    s.push_back(st(4'hA, 16'h5555, 16'h0000, 16'h0, 1'b0, 3'd3, CRW, 16'h0000, 3'b110));
    s.push_back(st(4'hE, 16'h1234, 16'h0000, 16'h0, 1'b0, 3'd3, CRW, 16'h1234, 3'b110));
    s.push_back(st(4'h9, 16'h8000, 16'h0000, 16'h0, 1'b0, 3'd3, CRW, 16'h8000, 3'b110));
    s.push_back(st(4'h8, 16'h0001, 16'h000F, 16'h0, 1'b0, 3'd3, CRW, 16'h8000, 3'b010));
    s.push_back(st(4'h9, 16'h8000, 16'hFFFF, 16'h000F, 1'b1, 3'd3, CRW, 16'h0001, 3'b000));
    s.push_back(st(4'h8, 16'h0003, 16'h0011, 16'h0, 1'b0, 3'd3, CRW, 16'h0006, 3'b000));
    s.push_back(st(4'h9, 16'h0003, 16'h0001, 16'h0, 1'b0, 3'd3, CRW, 16'h0001, 3'b100));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(s[i]); tick();
      e = sb.pop_front(); total++;
      if (((obs() ^ e.ev) & e.em) !== '0) begin
        bad++;
        $display("FAIL shift[%0d] got=%h want=%h", i, obs(), e.ev);
      end
    end
  endtask

  task automatic test_stall_flush();
    stim_t s[$];
    stim_t t, e;
    s.push_back(st(4'h4, 16'h0001, 16'h0002, 16'h0, 1'b0, 3'd3, CRW, 16'h0003, 3'b000));
    for (int k = 0; k < 3; k++) begin
      t = st(4'h4, 16'hFFFF, 16'h0001, 16'h0, 1'b0, 3'd4, 6'h3F, 16'h0, 3'b0);
      t.stall = 1'b1;
      t.ev = pk(16'h0003, 16'h0002, 16'h0, 3'd3, CRW, 3'b000);
      s.push_back(t);
    end
    s.push_back(st(4'h4, 16'hFFFF, 16'h0001, 16'h0, 1'b0, 3'd4, 6'b100001, 16'h0000, 3'b101));
    t = st(4'h4, 16'h0003, 16'h0004, 16'h0009, 1'b0, 3'd5, CST, 16'h0, 3'b0);
    t.stall = 1'b1; t.flush = 1'b1;
    t.ev = pk(16'h0, 16'h0, 16'h0, 3'd0, 6'h0, 3'b101);
    s.push_back(t);
    t = st(4'hC, 16'h0003, 16'h0004, 16'h0009, 1'b0, 3'd5, CRW, 16'h0, 3'b0);
    t.flush = 1'b1;
    t.ev = pk(16'h0, 16'h0, 16'h0, 3'd0, 6'h0, 3'b101);
    s.push_back(t);
    s.push_back(st(4'h0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 6'h0, 16'h0000, 3'b101));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(s[i]); tick();
      e = sb.pop_front(); total++;
      if (((obs() ^ e.ev) & e.em) !== '0) begin
        bad++;
        $display("FAIL stall_flush[%0d] got=%h want=%h", i, obs(), e.ev);
      end
    end
  endtask

  task automatic test_forwarding();
    stim_t s[$];
    stim_t t, e;
    t = st(4'h4, 16'h0005, 16'h0003, 16'h0, 1'b0, 3'd1, CRW, 16'h0008, 3'b000);
    t.rs = 3'd2; t.rt = 3'd3;
    s.push_back(t);
`ifdef FORWARDING_EN
    t = st(4'h4, 16'h0, 16'h0, 16'h0, 1'b0, 3'd2, CRW, 16'h0, 3'b0);
    t.rs = 3'd1; t.rt = 3'd1;
    t.ev = pk(16'h0010, 16'h0008, 16'h0, 3'd2, CRW, 3'b000);
    s.push_back(t);
    t = st(4'h4, 16'h0004, 16'h0005, 16'h0, 1'b0, 3'd3, CRW, 16'h0009, 3'b000);
    t.rs = 3'd4; t.rt = 3'd5;
    s.push_back(t);
    // EX/MEM (r3=9) must win over WB (r3=7).
    t = st(4'h4, 16'h0, 16'h0001, 16'h0, 1'b0, 3'd4, CRW, 16'h000A, 3'b000);
    t.rs = 3'd3; t.rt = 3'd6; t.wbwe = 1'b1; t.wba = 3'd3; t.wbd = 16'h0007;
    s.push_back(t);
    t = st(4'h4, 16'h0, 16'h0, 16'h0, 1'b0, 3'd4, CRW, 16'h0, 3'b0);
    t.rs = 3'd6; t.rt = 3'd6; t.wbwe = 1'b1; t.wba = 3'd6; t.wbd = 16'h0007;
    t.ev = pk(16'h000E, 16'h0007, 16'h0, 3'd4, CRW, 3'b000);
    s.push_back(t);
    t = st(4'h4, 16'h0100, 16'h0, 16'h0, 1'b0, 3'd5, CLD, 16'h0100, 3'b000);
    t.rs = 3'd2; t.rt = 3'd2;
    s.push_back(t);
    t = st(4'h4, 16'h0002, 16'h0003, 16'h0, 1'b0, 3'd1, CRW, 16'h0005, 3'b000);
    t.rs = 3'd5;
    s.push_back(t);
    t = st(4'h4, 16'h0001, 16'h0001, 16'h0, 1'b0, 3'd1, CRW, 16'h0002, 3'b000);
    t.rs = 3'd6; t.rt = 3'd6; t.wba = 3'd6; t.wbd = 16'h0007;
    s.push_back(t);
`else
    t = st(4'h4, 16'h0, 16'h0, 16'h0, 1'b0, 3'd2, CRW, 16'h0000, 3'b001);
    t.rs = 3'd1; t.rt = 3'd1; t.wbwe = 1'b1; t.wba = 3'd1; t.wbd = 16'h0007;
    s.push_back(t);
`endif
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(s[i]); tick();
      e = sb.pop_front(); total++;
      if (((obs() ^ e.ev) & e.em) !== '0) begin
        bad++;
        $display("FAIL forwarding[%0d] got=%h want=%h", i, obs(), e.ev);
      end
    end
  endtask

  task automatic test_store();
    stim_t s[$];
    stim_t e;
    s.push_back(st(4'h4, 16'h0120, 16'hABCD, 16'h0003, 1'b1, 3'd0, CST, 16'h0123, 3'b000));
    s.push_back(st(4'hA, 16'h0000, 16'hBEEF, 16'h0, 1'b0, 3'd0, CPU, 16'hBEEF, 3'b000));
    s.push_back(st(4'h0, 16'h0042, 16'h0, 16'h0, 1'b0, 3'd0, 6'b000011, 16'h0042, 3'b000));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(s[i]); tick();
      e = sb.pop_front(); total++;
      if (((obs() ^ e.ev) & e.em) !== '0) begin
        bad++;
        $display("FAIL store[%0d] got=%h want=%h", i, obs(), e.ev);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t t, e;
    logic [16:0] sum;
    logic [15:0] a, b;
    logic [5:0]  ctl;
    logic [2:0]  rd;
    for (int i = 0; i < 12; i++) begin
      a   = 16'($urandom());
      b   = (i == 0) ? 16'(-a) : 16'($urandom());
      ctl = 6'($urandom());
      rd  = 3'($urandom_range(5, 0));
      sum = {1'b0, a} + {1'b0, b};
      t = st(4'h4, a, b, 16'($urandom()), 1'b0, rd, ctl, sum[15:0],
             {sum[16], sum[15], sum[15:0] == 16'h0});
      apply(t); sb.push_back(t); tick();
      e = sb.pop_front(); total++;
      if (((obs() ^ e.ev) & e.em) !== '0) begin
        bad++;
        $display("FAIL back_to_back[%0d] got=%h want=%h", i, obs(), e.ev);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arith();
    test_shift_flags();
    test_stall_flush();
    test_forwarding();
    test_store();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
